// File: rtl/ram_port_master.sv
// ram_port_master
//   Turns a valid/ready request stream into a single-port RAM access. Each
//   accepted request yields one response, in acceptance order. Writes into
//   the low ROM_WORDS addresses (bootloader ROM) are rejected: they never
//   reach the RAM and answer with rsp_err = 1.
//
//   Request and RAM timing:
//     - The RAM port is driven combinationally from the accepted request.
//     - Read data comes back one cycle later on ram_rdData.
//     - Every response passes through a one-stage in-flight slot and then
//       a RSP_DEPTH-entry FIFO. A read is therefore visible on rsp_valid
//       two cycles after acceptance when the FIFO is empty.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_wr              1 = write, 0 = read
//   req_addr            word address
//   req_mask            byte enables (writes only)
//   req_wdata           write data
//   rsp_valid/ready     response handshake
//   rsp_rdata           read data (0 for write responses)
//   rsp_err             protected-region write rejected
//   ram_en, ram_wr      RAM enable and write strobe
//   ram_addr, ram_mask  RAM word address and byte enables
//   ram_wrData          RAM write data
//   ram_rdData          RAM read data, valid one cycle after a read enable
module ram_port_master #(
    parameter int ADDR_W    = 12,
    parameter int ROM_WORDS = 1024,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_mask,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_mask,
    output logic [31:0]       ram_wrData,
    input  logic [31:0]       ram_rdData
);

    localparam int PW = $clog2(RSP_DEPTH);
    // One spare bit so count + in-flight never wraps.
    localparam int CW = PW + 2;
    localparam logic [CW-1:0]     DEPTH_C   = CW'(RSP_DEPTH);
    localparam logic [ADDR_W:0]   ROM_LIMIT = (ADDR_W + 1)'(ROM_WORDS);

    // State
    logic          inflight_q, inflight_d;
    logic          slot_rd_q,  slot_rd_d;
    logic          slot_err_q, slot_err_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;

    logic [31:0]   fifo_data [RSP_DEPTH];
    logic          fifo_err  [RSP_DEPTH];

    // Combinational helpers
    logic          reject;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   push_data;
    logic [CW-1:0] occupancy;

    assign reject    = req_wr & ({1'b0, req_addr} < ROM_LIMIT);
    assign occupancy = count_q + CW'(inflight_q);

    assign rsp_valid = ~reset & (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Room is judged after this cycle's pop, so a full FIFO that is being
    // drained still accepts one new request per cycle.
    assign req_ready = ~reset & ((occupancy - CW'(pop)) < DEPTH_C);
    assign accept    = req_valid & req_ready;

    assign ram_en     = accept & ~reject;
    assign ram_wr     = ram_en & req_wr;
    assign ram_addr   = req_addr;
    assign ram_mask   = req_mask;
    assign ram_wrData = req_wdata;

    // The in-flight slot always drains into the FIFO on the following cycle;
    // only reads carry RAM data, writes and rejects carry zero.
    assign push      = inflight_q;
    assign push_data = slot_rd_q ? ram_rdData : 32'h0;

    // Head entry is masked to zero when empty so stale storage never shows.
    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr_q] : 32'h0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr_q]  : 1'b0;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally) so no latch is inferred.
        inflight_d = accept;
        slot_rd_d  = accept & ~req_wr;
        slot_err_d = accept & reject;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            slot_rd_q  <= 1'b0;
            slot_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            slot_rd_q  <= slot_rd_d;
            slot_err_q <= slot_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q decides which
    // entries are live, and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_data[wr_ptr_q] <= push_data;
            fifo_err[wr_ptr_q]  <= slot_err_q;
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Self-checking bench for ram_port_master. Directed requests push their
// hand-computed response into a scoreboard queue; a monitor pops and
// compares on every rsp_valid & rsp_ready. A behavioural RAM model answers
// reads one cycle after ram_en, initialised so that word i holds i.
module tb_ram_port_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [11:0] req_addr;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic        ram_wr;
    logic [11:0] ram_addr;
    logic [3:0]  ram_mask;
    logic [31:0] ram_wrData;
    logic [31:0] ram_rdData;

    ram_port_master #(.ADDR_W(12), .ROM_WORDS(1024), .RSP_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_mask(ram_mask), .ram_wrData(ram_wrData), .ram_rdData(ram_rdData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          pop_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          pops = 0;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          last_acc_cyc = 0;
    int          last_pop_cyc = 0;
    logic [31:0] mem [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // RAM model: one-cycle read latency, byte-masked writes.
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_wr) begin
                for (int b = 0; b < 4; b++)
                    if (ram_mask[b]) mem[ram_addr][b*8 +: 8] <= ram_wrData[b*8 +: 8];
            end else begin
                ram_rdData <= mem[ram_addr];
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (ram_en) en_cnt++;
        if (ram_wr) wr_cnt++;
        if (rsp_valid && rsp_ready) begin
            pops++;
            pop_cyc.push_back(cyc);
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got rdata=%h err=%b expected none", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Presents one request and waits (bounded) for its acceptance; returns
    // just after the accepting edge so requests can be issued back-to-back.
    task automatic send(input logic wr, input logic [11:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
        bit done = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = data;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_t e;
                e.rdata = exp_rd;
                e.err   = exp_err;
                sb.push_back(e);
                accepted++;
                last_acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout addr=%h got no accept expected accept", addr);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) done = 1;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int a0;
        int p0;

        reset     = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 12'h700;
        req_mask  = 4'h0;
        req_wdata = 32'h0;
        ram_rdData = 32'h0;

        // Reset state with a request pending: nothing may be accepted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        rsp_ready = 1'b1;

        // Write then read back 0x400; one write strobe, read latency of 2.
        c0 = wr_cnt;
        send(1'b1, 12'h400, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        send(1'b0, 12'h400, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        idle();
        drain();
        check("wr_pulses", 32'(wr_cnt - c0), 32'd1);
        check("rd_latency", 32'(last_pop_cyc - last_acc_cyc), 32'd2);

        // Partial-mask write over initial 0x00000401, plus a legal ROM read.
        send(1'b1, 12'h401, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0);
        send(1'b0, 12'h401, 4'h0, 32'h0, 32'h00BB04DD, 1'b0);
        send(1'b0, 12'h010, 4'h0, 32'h0, 32'h00000010, 1'b0);
        idle();
        drain();

        // Protected write: no RAM access, error response, word unchanged.
        c0 = en_cnt;
        send(1'b1, 12'h3FF, 4'hF, 32'h12345678, 32'h0, 1'b1);
        idle();
        drain();
        check("rom_no_ram_en", 32'(en_cnt - c0), 32'd0);
        send(1'b0, 12'h3FF, 4'h0, 32'h0, 32'h000003FF, 1'b0);
        idle();
        drain();

        // Backpressure: only RSP_DEPTH accepted while rsp_ready is low.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        a0 = accepted;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(1'b0, 12'(12'h600 + i), 4'h0, 32'h0, 32'(32'h600 + i), 1'b0);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_accepted", 32'(accepted - a0), 32'd2);
                check("bp_req_ready", 32'(req_ready), 32'h0);
                check("bp_ram_en", 32'(ram_en), 32'h0);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Streaming 16 reads: one acceptance per cycle, responses gap-free.
        pop_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            send(1'b0, 12'(12'h500 + i), 4'h0, 32'h0, 32'(32'h500 + i), 1'b0);
        check("stream_cycles", 32'(cyc - c0), 32'd16);
        idle();
        drain();
        check("stream_rsp_count", 32'(pop_cyc.size()), 32'd16);
        if (pop_cyc.size() == 16)
            check("stream_rsp_span", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);

        // Fill the FIFO, then push and pop together through the pointer wrap.
        rsp_ready = 1'b0;
        send(1'b0, 12'h610, 4'h0, 32'h0, 32'h610, 1'b0);
        send(1'b0, 12'h611, 4'h0, 32'h0, 32'h611, 1'b0);
        req_addr = 12'h612;
        @(negedge clk);
        @(negedge clk);
        check("full_req_ready", 32'(req_ready), 32'h0);
        check("full_ram_en", 32'(ram_en), 32'h0);
        check("full_rsp_head", rsp_rdata, 32'h610);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 2; i < 8; i++)
            send(1'b0, 12'(12'h610 + i), 4'h0, 32'h0, 32'(32'h610 + i), 1'b0);
        idle();
        drain();

        // Reset with one read in flight and one response queued.
        rsp_ready = 1'b0;
        send(1'b0, 12'h620, 4'h0, 32'h0, 32'h620, 1'b0);
        send(1'b0, 12'h621, 4'h0, 32'h0, 32'h621, 1'b0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_ram_en", 32'(ram_en), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_rst_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        p0 = pops;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(pops - p0), 32'd0);

        // Normal operation resumes after the mid-run reset.
        send(1'b0, 12'h622, 4'h0, 32'h0, 32'h622, 1'b0);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
